// File: rtl/decrypt_block_framer.sv
// ============================================================================
// Module  : decrypt_block_framer
// Purpose : Packs ciphertext bytes into 128-bit blocks for a combinational
//           decrypt core, waits for it to settle, then holds the plaintext.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module decrypt_block_framer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [127:0]  key_in,
   input  logic          key_load,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          flush,
   output logic [127:0]  core_key,
   output logic [127:0]  core_cipher,
   input  logic [127:0]  core_plain,
   output logic [127:0]  out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy
);

   localparam logic [1:0] c_fill   = 2'd0;
   localparam logic [1:0] c_settle = 2'd1;
   localparam logic [1:0] c_hold   = 2'd2;

   localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);

   logic [1:0] r_state;
   logic [3:0] r_byte_cnt;
   logic [3:0] r_settle_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= c_fill;
         r_byte_cnt   <= 4'd0;
         r_settle_cnt <= 4'd0;
         core_key     <= 128'd0;
         core_cipher  <= 128'd0;
         out_data     <= 128'd0;
      end else begin
         case (r_state)
            c_fill: begin
               // Key is only swappable on a block boundary.
               if (key_load && (r_byte_cnt == 4'd0)) begin
                  core_key <= key_in;
               end
               if (flush) begin
                  r_byte_cnt  <= 4'd0;
                  core_cipher <= 128'd0;
               end else if (in_valid) begin
                  core_cipher <= {core_cipher[119:0], in_data};
                  r_byte_cnt  <= r_byte_cnt + 4'd1;
                  if (r_byte_cnt == 4'd15) begin
                     r_state      <= c_settle;
                     r_settle_cnt <= 4'd0;
                  end
               end
            end
            c_settle: begin
               r_settle_cnt <= r_settle_cnt + 4'd1;
               if (r_settle_cnt == c_settle_last) begin
                  out_data <= core_plain;
                  r_state  <= c_hold;
               end
            end
            c_hold: begin
               if (out_ready) begin
                  r_state <= c_fill;
               end
            end
            default: begin
               r_state <= c_fill;
            end
         endcase
      end
   end

   always_comb begin
      in_ready  = (r_state == c_fill);
      out_valid = (r_state == c_hold);
      busy      = (r_state != c_fill) || (r_byte_cnt != 4'd0);
   end

endmodule

`default_nettype wire

// File: tb/tb_decrypt_block_framer.sv
// ============================================================================
// Module  : tb_decrypt_block_framer
// Purpose : Directed and randomized checks of decrypt_block_framer against a
//           byte-history model, with a stand-in combinational decrypt core.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_decrypt_block_framer;

   localparam int S = 2;
   localparam logic [127:0] c_aes_key = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] c_aes_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] c_aes_pt  = 128'h00112233445566778899aabbccddeeff;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [127:0]  key_in = '0;
   logic          key_load = 1'b0;
   logic [7:0]    in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          flush = 1'b0;
   logic [127:0]  core_key;
   logic [127:0]  core_cipher;
   logic [127:0]  core_plain;
   logic [127:0]  out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          busy;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   decrypt_block_framer #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .core_key(core_key), .core_cipher(core_cipher),
      .core_plain(core_plain), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
   );

   // Stand-in core: the known AES vector, otherwise a keyed scramble.
   function automatic logic [127:0] core_fn(input logic [127:0] c, input logic [127:0] k);
      if (c == c_aes_ct && k == c_aes_key) return c_aes_pt;
      return c ^ {k[63:0], k[127:64]};
   endfunction

   assign core_plain = core_fn(core_cipher, core_key);

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   // Model: history of bytes since the last clear, plus block-level timing.
   logic [7:0]   m_hist[$];
   logic [127:0] m_key  = '0;
   logic [127:0] m_out  = '0;
   int           m_cnt  = 0;
   int           m_wait = 0;
   bit           m_hold = 1'b0;
   int           m_deliv = 0;
   int           d_deliv = 0;

   function automatic logic [127:0] m_cipher();
      logic [127:0] r = '0;
      foreach (m_hist[i]) r = {r[119:0], m_hist[i]};
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_hist.delete();
         m_key = '0; m_out = '0; m_cnt = 0; m_wait = 0; m_hold = 1'b0;
      end else if (m_hold) begin
         if (out_ready) begin
            m_hold = 1'b0;
            m_deliv++;
         end
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) begin
            m_hold = 1'b1;
            m_out  = core_fn(m_cipher(), m_key);
         end
      end else begin
         if (key_load && m_cnt == 0) m_key = key_in;
         if (flush) begin
            m_hist.delete();
            m_cnt = 0;
         end else if (in_valid) begin
            m_hist.push_back(in_data);
            if (m_hist.size() > 16) void'(m_hist.pop_front());
            m_cnt = (m_cnt + 1) % 16;
            if (m_cnt == 0) m_wait = S;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready",    {127'd0, in_ready},  {127'd0, !(m_wait > 0 || m_hold)});
         chk("out_valid",   {127'd0, out_valid}, {127'd0, m_hold});
         chk("busy",        {127'd0, busy},      {127'd0, (m_wait > 0 || m_hold || m_cnt != 0)});
         chk("core_key",    core_key,    m_key);
         chk("core_cipher", core_cipher, m_cipher());
         chk("out_data",    out_data,    m_out);
         if (out_valid && out_ready && !rst) d_deliv++;
      end
   end

   task automatic put(input logic [7:0] b);
      int n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (!in_ready) chk("put_timeout", 128'd0, 128'd1);
      in_valid = 1'b1; in_data = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      if (!out_valid) chk("drain_timeout", 128'd0, 128'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [127:0] v;
      logic [127:0] held;

      @(negedge clk);
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_in_ready",  {127'd0, in_ready},  128'd1);
      chk("rst_busy",      {127'd0, busy},      128'd0);
      chk("rst_core_key",  core_key,  128'd0);
      chk("rst_out_data",  out_data,  128'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Known decrypt vector and its latency.
      key_load = 1'b1; key_in = c_aes_key;
      @(negedge clk);
      key_load = 1'b0;
      chk("key_loaded", core_key, c_aes_key);
      v = c_aes_ct;
      for (int i = 0; i < 16; i++) put(v[127-8*i -: 8]);
      chk("aes_ct", core_cipher, c_aes_ct);
      chk("lat_T1", {127'd0, out_valid}, 128'd0);
      @(negedge clk);
      chk("lat_T2", {127'd0, out_valid}, 128'd0);
      @(negedge clk);
      chk("lat_T3", {127'd0, out_valid}, 128'd1);
      chk("aes_pt", out_data, c_aes_pt);

      // Backpressure in HOLD, with ignored key_load and in_valid.
      held = out_data;
      for (int i = 0; i < 10; i++) begin
         chk("hold_valid", {127'd0, out_valid}, 128'd1);
         chk("hold_ready", {127'd0, in_ready},  128'd0);
         chk("hold_data",  out_data, held);
         key_load = (i == 3); key_in = 128'hdead_beef;
         in_valid = 1'b1; in_data = 8'h5a;
         @(negedge clk);
      end
      key_load = 1'b0; in_valid = 1'b0;
      chk("hold_key", core_key, c_aes_key);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_valid", {127'd0, out_valid}, 128'd0);
      chk("release_ready", {127'd0, in_ready},  128'd1);

      // Partial block, mid-block key_load, flush with a dropped byte.
      for (int i = 0; i < 5; i++) put(8'(8'ha0 + i));
      key_load = 1'b1; key_in = ~c_aes_key;
      @(negedge clk);
      key_load = 1'b0;
      chk("midblk_key", core_key, c_aes_key);
      put(8'ha5); put(8'ha6);
      flush = 1'b1; in_valid = 1'b1; in_data = 8'hee;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_cipher", core_cipher, 128'd0);
      chk("flush_busy",   {127'd0, busy}, 128'd0);
      for (int i = 0; i < 16; i++) put(8'(8'h10 + i));
      chk("post_flush_ct", core_cipher, 128'h101112131415161718191a1b1c1d1e1f);
      drain();

      // Reset during SETTLE.
      for (int i = 0; i < 16; i++) put(8'(i * 7));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("srst_ready", {127'd0, in_ready},  128'd1);
      chk("srst_busy",  {127'd0, busy},      128'd0);
      for (int i = 0; i < 5; i++) begin
         chk("srst_no_valid", {127'd0, out_valid}, 128'd0);
         @(negedge clk);
      end

      // Gapped back-to-back blocks, downstream always ready.
      key_load = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      key_load = 1'b0;
      out_ready = 1'b1;
      for (int b = 0; b < 20; b++) begin
         for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            put(8'($urandom));
         end
      end
      repeat (S + 3) @(negedge clk);
      out_ready = 1'b0;
      chk("deliv_count", 128'(d_deliv), 128'(m_deliv));
      chk("deliv_min",   128'(m_deliv >= 21), 128'd1);

      // Fully random control traffic.
      for (int c = 0; c < 1500; c++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         in_data   = 8'($urandom);
         flush     = ($urandom_range(0, 39) == 0);
         key_load  = ($urandom_range(0, 29) == 0);
         key_in    = {$urandom, $urandom, $urandom, $urandom};
         out_ready = ($urandom_range(0, 1) == 1);
         rst       = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      in_valid = 1'b0; flush = 1'b0; key_load = 1'b0; rst = 1'b0; out_ready = 1'b1;
      repeat (S + 3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
